// File: rtl/risc16_ctrl_if.sv
// Control-side bundle between the risc16 control FSM and the shared datapath/memory.
// The master modport is the FSM; the slave modport is the datapath/memory side.
interface risc16_ctrl_if;
    logic [2:0] opcode;
    logic       ra_is_zero;
    logic       eq_in;
    logic       mem_ack;

    logic       alu_add;
    logic       alu_nand;
    logic       alu_pass1;
    logic       alu_eq;
    logic [1:0] src1_sel;
    logic [1:0] src2_sel;
    logic       ir_we;
    logic       aluout_we;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       retire;
    logic       err;

    modport master (
        input  opcode, ra_is_zero, eq_in, mem_ack,
        output alu_add, alu_nand, alu_pass1, alu_eq, src1_sel, src2_sel,
               ir_we, aluout_we, rf_we, pc_we, pc_sel, wb_sel,
               mem_req, mem_we, addr_sel, retire, err
    );

    modport slave (
        output opcode, ra_is_zero, eq_in, mem_ack,
        input  alu_add, alu_nand, alu_pass1, alu_eq, src1_sel, src2_sel,
               ir_we, aluout_we, rf_we, pc_we, pc_sel, wb_sel,
               mem_req, mem_we, addr_sel, retire, err
    );
endinterface

// File: rtl/risc16_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the risc16 datapath.
// Outputs are decoded from the registered state and forced low while rst is high.
module risc16_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    risc16_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       taken_q, taken_d;
    logic [2:0] op_q, op_d;
    logic       timed_out;

    always_comb begin
        state_d   = state_q;
        taken_d   = taken_q;
        op_d      = op_q;
        timed_out = (cnt_q == CNT_LAST);
        unique case (state_q)
            S_FETCH: begin
                if (bus.mem_ack) begin
                    state_d = S_DECODE;
                    op_d    = bus.opcode;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (op_q == OP_BEQ) taken_d = bus.eq_in;
                state_d = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (bus.mem_ack)    state_d = S_WB;
                else if (timed_out) state_d = S_ERROR;
            end
            S_WB:    state_d = S_FETCH;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_FETCH;
        endcase

        // The wait counter only runs while parked on an unanswered memory request.
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == S_FETCH || state_q == S_MEM)
            cnt_d = cnt_q + 8'd1;
        else
            cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            taken_q <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
            op_q    <= op_d;
        end
    end

    logic       add_o, nand_o, pass1_o, eq_o;
    logic [1:0] src1_o, src2_o, pc_sel_o, wb_sel_o;
    logic       ir_we_o, aluout_we_o, rf_we_o, pc_we_o;
    logic       mem_req_o, mem_we_o, addr_sel_o, retire_o, err_o;

    always_comb begin
        add_o       = 1'b0;
        nand_o      = 1'b0;
        pass1_o     = 1'b0;
        eq_o        = 1'b0;
        src1_o      = 2'd0;
        src2_o      = 2'd0;
        pc_sel_o    = 2'd0;
        wb_sel_o    = 2'd0;
        ir_we_o     = 1'b0;
        aluout_we_o = 1'b0;
        rf_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        addr_sel_o  = 1'b0;
        retire_o    = 1'b0;
        err_o       = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req_o = 1'b1;
                    ir_we_o   = bus.mem_ack;
                end
                S_DECODE: ;
                S_EXEC: begin
                    aluout_we_o = 1'b1;
                    unique case (op_q)
                        OP_ADD:               add_o = 1'b1;
                        OP_ADDI, OP_LW, OP_SW: begin
                            add_o  = 1'b1;
                            src2_o = 2'd1;
                        end
                        OP_NAND:              nand_o = 1'b1;
                        OP_LUI: begin
                            pass1_o = 1'b1;
                            src1_o  = 2'd2;
                        end
                        OP_BEQ: begin
                            eq_o   = 1'b1;
                            src2_o = 2'd2;
                        end
                        OP_JALR:              pass1_o = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req_o  = 1'b1;
                    addr_sel_o = 1'b1;
                    mem_we_o   = (op_q == OP_SW);
                end
                S_WB: begin
                    pc_we_o  = 1'b1;
                    retire_o = 1'b1;
                    if (op_q == OP_BEQ && taken_q) pc_sel_o = 2'd1;
                    else if (op_q == OP_JALR)      pc_sel_o = 2'd2;
                    unique case (op_q)
                        OP_ADD, OP_ADDI, OP_NAND, OP_LUI: rf_we_o = !bus.ra_is_zero;
                        OP_LW: begin
                            rf_we_o  = !bus.ra_is_zero;
                            wb_sel_o = 2'd1;
                        end
                        OP_JALR: begin
                            rf_we_o  = !bus.ra_is_zero;
                            wb_sel_o = 2'd2;
                        end
                        default: ;
                    endcase
                end
                S_ERROR: err_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.alu_add   = add_o;
    assign bus.alu_nand  = nand_o;
    assign bus.alu_pass1 = pass1_o;
    assign bus.alu_eq    = eq_o;
    assign bus.src1_sel  = src1_o;
    assign bus.src2_sel  = src2_o;
    assign bus.ir_we     = ir_we_o;
    assign bus.aluout_we = aluout_we_o;
    assign bus.rf_we     = rf_we_o;
    assign bus.pc_we     = pc_we_o;
    assign bus.pc_sel    = pc_sel_o;
    assign bus.wb_sel    = wb_sel_o;
    assign bus.mem_req   = mem_req_o;
    assign bus.mem_we    = mem_we_o;
    assign bus.addr_sel  = addr_sel_o;
    assign bus.retire    = retire_o;
    assign bus.err       = err_o;
endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// Self-checking bench for risc16_ctrl_fsm: per-cycle output model, vector table, random programs,
// and hand-written timeout / reset corner sequences.
module tb_risc16_ctrl_fsm;
    logic clk;
    logic rst;

    risc16_ctrl_if b();

    risc16_ctrl_fsm #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       f_add, f_nand, f_pass1, f_eq;
        logic [1:0] s1, s2;
        logic       ir_we, aluout_we, rf_we, pc_we;
        logic [1:0] pc_sel, wb_sel;
        logic       mem_req, mem_we, addr_sel, retire, err;
    } outs_t;

    typedef enum int {P_RST, P_FW, P_FA, P_DEC, P_EX, P_MW, P_MA, P_WB, P_ER} phase_t;

    typedef struct {
        logic [2:0] op;
        logic       raz;
        int         fw;
        int         mw;
        logic       eqe;
        logic       eqw;
        logic       x_rf_we;
        logic [1:0] x_pc_sel;
        logic [1:0] x_wb_sel;
        logic       chk_wb;
        int         x_lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit is_mem(logic [2:0] op);
        return (op == 3'd4) || (op == 3'd5);
    endfunction

    // Expected outputs for one cycle, straight from the per-state rules of the controller.
    function automatic outs_t model(phase_t ph, logic [2:0] op, logic raz, logic taken);
        outs_t o;
        o = '0;
        case (ph)
            P_FW: o.mem_req = 1'b1;
            P_FA: begin o.mem_req = 1'b1; o.ir_we = 1'b1; end
            P_EX: begin
                o.aluout_we = 1'b1;
                case (op)
                    3'd0:             o.f_add = 1'b1;
                    3'd1, 3'd4, 3'd5: begin o.f_add = 1'b1; o.s2 = 2'd1; end
                    3'd2:             o.f_nand = 1'b1;
                    3'd3:             begin o.f_pass1 = 1'b1; o.s1 = 2'd2; end
                    3'd6:             begin o.f_eq = 1'b1; o.s2 = 2'd2; end
                    default:          o.f_pass1 = 1'b1;
                endcase
            end
            P_MW, P_MA: begin
                o.mem_req  = 1'b1;
                o.addr_sel = 1'b1;
                o.mem_we   = (op == 3'd4);
            end
            P_WB: begin
                o.pc_we  = 1'b1;
                o.retire = 1'b1;
                o.pc_sel = (op == 3'd6 && taken) ? 2'd1 : (op == 3'd7) ? 2'd2 : 2'd0;
                o.rf_we  = !(op == 3'd4 || op == 3'd6) && !raz;
                o.wb_sel = (op == 3'd5) ? 2'd1 : (op == 3'd7) ? 2'd2 : 2'd0;
            end
            P_ER: o.err = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t care(phase_t ph, logic [2:0] op);
        outs_t m;
        m = '1;
        if (ph == P_EX && (op == 3'd3 || op == 3'd7)) m.s2 = 2'd0;
        if (ph == P_WB && (op == 3'd4 || op == 3'd6)) m.wb_sel = 2'd0;
        return m;
    endfunction

    function automatic outs_t sample();
        return {b.alu_add, b.alu_nand, b.alu_pass1, b.alu_eq, b.src1_sel, b.src2_sel,
                b.ir_we, b.aluout_we, b.rf_we, b.pc_we, b.pc_sel, b.wb_sel,
                b.mem_req, b.mem_we, b.addr_sel, b.retire, b.err};
    endfunction

    task automatic check_outs(input string nm, input outs_t exp, input outs_t m);
        outs_t act;
        act = sample();
        n_checks++;
        if (((act ^ exp) & m) != '0) begin
            n_fail++;
            $display("FAIL %s: outputs got %h expected %h (care %h) at %0t", nm, act, exp, m, $time);
        end
    endtask

    task automatic check_val(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive away from the rising edge, then compare against the model.
    task automatic step(input logic r, input logic [2:0] op_in, input logic raz, input logic eq,
                        input logic ack, input phase_t ph, input logic [2:0] mop,
                        input logic taken, input string nm);
        @(negedge clk);
        rst          = r;
        b.opcode     = op_in;
        b.ra_is_zero = raz;
        b.eq_in      = eq;
        b.mem_ack    = ack;
        #1;
        check_outs(nm, model(ph, mop, raz, taken), care(ph, mop));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 3'($urandom), 1'b0, 1'($urandom), 1'b1, P_RST, 3'd0, 1'b0, "reset_outs");
    endtask

    task automatic go_to_mem(input logic [2:0] op);
        step(1'b0, op, 1'b0, 1'($urandom), 1'b1, P_FA, op, 1'b0, "gm_fetch");
        step(1'b0, 3'($urandom), 1'b0, 1'($urandom), 1'($urandom), P_DEC, op, 1'b0, "gm_decode");
        step(1'b0, 3'($urandom), 1'b0, 1'($urandom), 1'($urandom), P_EX, op, 1'b0, "gm_exec");
    endtask

    // Runs one complete instruction, checking every cycle, and reports what was seen at writeback.
    task automatic run_instr(input logic [2:0] op, input logic raz, input int fw, input int mw,
                             input logic eqe, input logic eqw,
                             output logic o_rf_we, output logic [1:0] o_pc_sel,
                             output logic [1:0] o_wb_sel, output int o_lat);
        int   cyc;
        logic taken;
        cyc   = 0;
        o_lat = 0;
        taken = (op == 3'd6) && eqe;
        for (int i = 0; i < fw; i++) begin
            step(1'b0, op, raz, 1'($urandom), 1'b0, P_FW, op, taken, "fetch_wait");
            cyc++; if (b.retire && o_lat == 0) o_lat = cyc;
        end
        step(1'b0, op, raz, 1'($urandom), 1'b1, P_FA, op, taken, "fetch_ack");
        cyc++; if (b.retire && o_lat == 0) o_lat = cyc;
        step(1'b0, 3'($urandom), raz, 1'($urandom), 1'($urandom), P_DEC, op, taken, "decode");
        cyc++; if (b.retire && o_lat == 0) o_lat = cyc;
        step(1'b0, 3'($urandom), raz, eqe, 1'($urandom), P_EX, op, taken, "exec");
        cyc++; if (b.retire && o_lat == 0) o_lat = cyc;
        if (is_mem(op)) begin
            for (int i = 0; i < mw; i++) begin
                step(1'b0, 3'($urandom), raz, 1'($urandom), 1'b0, P_MW, op, taken, "mem_wait");
                cyc++; if (b.retire && o_lat == 0) o_lat = cyc;
            end
            step(1'b0, 3'($urandom), raz, 1'($urandom), 1'b1, P_MA, op, taken, "mem_ack");
            cyc++; if (b.retire && o_lat == 0) o_lat = cyc;
        end
        step(1'b0, 3'($urandom), raz, eqw, 1'($urandom), P_WB, op, taken, "writeback");
        cyc++; if (b.retire && o_lat == 0) o_lat = cyc;
        o_rf_we  = b.rf_we;
        o_pc_sel = b.pc_sel;
        o_wb_sel = b.wb_sel;
    endtask

    vec_t vecs[10];

    initial begin
        logic       rf;
        logic [1:0] ps, ws;
        int         lat, rcount;

        vecs[0] = '{3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 4};
        vecs[1] = '{3'd5, 1'b0, 0, 3, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 8};
        vecs[2] = '{3'd6, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 4};
        vecs[3] = '{3'd6, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4};
        vecs[4] = '{3'd1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 4};
        vecs[5] = '{3'd7, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 4};
        vecs[6] = '{3'd4, 1'b0, 1, 2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 8};
        vecs[7] = '{3'd2, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 6};
        vecs[8] = '{3'd3, 1'b0, 3, 0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 7};
        vecs[9] = '{3'd5, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 5};

        rst = 1'b1;
        b.opcode = 3'd0; b.ra_is_zero = 1'b0; b.eq_in = 1'b0; b.mem_ack = 1'b0;
        do_reset(2);

        // Back-to-back add with ack tied high: retire on every fourth cycle.
        rcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst = 1'b0; b.opcode = 3'd0; b.mem_ack = 1'b1; b.ra_is_zero = 1'b0;
            #1;
            check_val("b2b_retire", int'(b.retire), (i % 4 == 3) ? 1 : 0);
            if (i % 4 == 2) check_val("b2b_alu_add", int'(b.alu_add), 1);
            if (b.retire) rcount++;
        end
        check_val("b2b_retire_count", rcount, 3);

        for (int i = 0; i < 10; i++) begin
            run_instr(vecs[i].op, vecs[i].raz, vecs[i].fw, vecs[i].mw, vecs[i].eqe, vecs[i].eqw,
                      rf, ps, ws, lat);
            check_val("vec_rf_we", int'(rf), int'(vecs[i].x_rf_we));
            check_val("vec_pc_sel", int'(ps), int'(vecs[i].x_pc_sel));
            if (vecs[i].chk_wb) check_val("vec_wb_sel", int'(ws), int'(vecs[i].x_wb_sel));
            check_val("vec_latency", lat, vecs[i].x_lat);
        end

        // Fetch timeout: four unanswered cycles, then a sticky error that ignores ack.
        for (int i = 0; i < 4; i++)
            step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, P_FW, 3'd0, 1'b0, "to_fetch_wait");
        for (int i = 0; i < 4; i++)
            step(1'b0, 3'($urandom), 1'b0, 1'($urandom), 1'($urandom), P_ER, 3'd0, 1'b0, "to_fetch_err");
        do_reset(1);
        run_instr(3'd0, 1'b0, 3, 0, 1'b0, 1'b0, rf, ps, ws, lat);
        check_val("after_err_latency", lat, 7);

        // Timeout while waiting on the data access.
        go_to_mem(3'd5);
        for (int i = 0; i < 4; i++)
            step(1'b0, 3'($urandom), 1'b0, 1'b0, 1'b0, P_MW, 3'd5, 1'b0, "to_mem_wait");
        step(1'b0, 3'($urandom), 1'b0, 1'b0, 1'b1, P_ER, 3'd0, 1'b0, "to_mem_err");
        do_reset(1);

        // Reset in the middle of a store: nothing asserted in the reset cycle, fetch resumes.
        go_to_mem(3'd4);
        step(1'b0, 3'($urandom), 1'b0, 1'b0, 1'b0, P_MW, 3'd4, 1'b0, "sw_mem_wait");
        step(1'b1, 3'($urandom), 1'b0, 1'b0, 1'b1, P_RST, 3'd0, 1'b0, "sw_reset_cycle");
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, P_FW, 3'd0, 1'b0, "sw_refetch");
        run_instr(3'd0, 1'b0, 0, 0, 1'b0, 1'b0, rf, ps, ws, lat);
        check_val("post_rst_latency", lat, 4);

        // Random programs against the model; ack delays stay below the timeout.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic       raz, eqe, eqw;
            int         fw, mw, xlat;
            op  = 3'($urandom);
            raz = 1'($urandom_range(0, 3) == 0);
            eqe = 1'($urandom);
            eqw = 1'($urandom);
            fw  = $urandom_range(0, 3);
            mw  = $urandom_range(0, 3);
            xlat = 4 + fw + (is_mem(op) ? 1 + mw : 0);
            run_instr(op, raz, fw, mw, eqe, eqw, rf, ps, ws, lat);
            check_val("rand_latency", lat, xlat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
